m_div_unit: RTL
===============

Name: m_div_unit

Overview:
- Multi-cycle divide/remainder unit for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits directly downstream of the instruction decoder. It consumes the decoder's m_con code and alu_mul_sel qualifier together with the register-file operands.
- Returns a result to the write-back mux and holds the pipeline with busy while iterating.
- Uses a radix-2 restoring algorithm on magnitudes, followed by a sign fix-up.

Parameters:
- XLEN, 32, operand/result width. Must be at least 8.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; qualified by alu_mul_sel from the decoder.
- m_con  input  4  op code: 4'b1000 DIV, 4'b1001 DIVU, 4'b1010 REM, 4'b1011 REMU.
- rs1_data  input  XLEN  dividend.
- rs2_data  input  XLEN  divisor.
- kill  input  1  pipeline flush; abort any operation in flight.
- busy  output  1  unit occupied; the pipeline must stall.
- done  output  1  single-cycle result-valid pulse.
- result  output  XLEN  quotient or remainder. Held stable until the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, result=0, counter=0.
  - All internal registers cleared.
  - Deassertion is clean mid-operation: the unit restarts from IDLE and no done is produced.
- Accept rule: start=1 AND m_con[3:2]=2'b10 AND state==IDLE AND kill=0.
  - Operands and op are captured on that edge.
  - start is ignored in any other state, or with any other m_con value.
- States:
  - IDLE: busy=0. On accept, go to DONE if a special case applies, else go to CALC.
  - CALC: busy=1. The counter runs 0..XLEN-1. Each cycle: rem = {rem[XLEN-2:0], dvd[XLEN-1]}, dvd shifts left; if rem >= |divisor|, subtract and set quotient bit 1.
    - Goes to FIX when counter==XLEN-1.
  - FIX: busy=1.
    - Signed ops: quotient negated if the operand signs differ; remainder takes the dividend's sign.
    - Selects quotient or remainder by m_con[1].
    - Registers result. Goes to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Goes to IDLE.
- Latency:
  - Normal: done is high in the cycle following the XLEN+2-th edge after the accepting edge (34 cycles for XLEN=32).
  - Special case: done is high in the cycle following the 1st edge after accept.
- Special cases, detected at accept:
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend.
  - Signed overflow (DIV/REM with dividend = -2^(XLEN-1) and divisor = -1): quotient = -2^(XLEN-1); remainder = 0.
- Unsigned ops use the operands directly. Signed ops take two's-complement magnitudes at accept.
- kill=1 in CALC or FIX: go to IDLE next edge, no done, result unchanged. kill in DONE: done still completes (result already committed).
- Simultaneous kill and start in IDLE: kill wins; no accept.
- busy is combinational from state, so the stall takes effect the cycle after accept. The decoder/hazard logic holds the instruction until done.

Optional Feature:
- Macro: M_DIV_RESULT_REUSE_EN.
- Defined:
  - Last operands, signedness, quotient and remainder are stored on every normal completion.
  - A later accept with identical rs1_data, rs2_data and signedness (DIV/REM pair or DIVU/REMU pair) goes straight to DONE with the stored value. Latency is 1 cycle, as for the special cases.
  - Stored-value valid flag is cleared by reset and by kill.
- Undefined: no storage; every op takes full latency.

Decomposition:
- Package m_ext_pkg:
  - m_op_e enum with DIV=4'b1000, DIVU=4'b1001, REM=4'b1010, REMU=4'b1011. The decoder also moves to this enum.
  - div_state_e {IDLE, CALC, FIX, DONE}.
  - XLEN default constant.
- Sub-module div_step: combinational single iteration (shift, compare, subtract). Instantiated once in m_div_unit.

Test Plan:
- DIVU 100/7 -> result 14, done at cycle 34, busy high during cycles 1..33.
- REM -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFF. DIV same operands -> 0xFFFFFFFD.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each done 1 cycle after accept.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0, 1-cycle latency.
- DIVU accepted, kill at cycle 10 -> no done, busy drops next cycle, result unchanged. rst_n pulsed mid-CALC -> all outputs 0 immediately.
- With M_DIV_RESULT_REUSE_EN: DIV 100/7 then REM 100/7 -> 14 then 2, second done 1 cycle after accept. Without the macro -> second op takes 34 cycles.

Source files
------------

// File: rtl/m_ext_pkg.sv
// Shared types for the RV32M divide path: op codes, divider FSM states, default width.
package m_ext_pkg;

  localparam int unsigned M_XLEN = 32;

  typedef enum logic [3:0] {
    DIV  = 4'b1000,
    DIVU = 4'b1001,
    REM  = 4'b1010,
    REMU = 4'b1011
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/m_div_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor magnitude and produce one quotient bit.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_dvd,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_dvd,
  output logic            o_qbit
);

  // One extra bit: the shifted remainder can exceed XLEN bits before the subtract.
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_sub;

  // Shift, compare, conditionally subtract.
  always_comb begin
    w_shift = {i_rem, i_dvd[XLEN-1]};
    // Result is below the divisor whenever it is used, so XLEN bits suffice.
    w_sub   = w_shift[XLEN-1:0] - i_dvs;
    o_qbit  = (w_shift >= {1'b0, i_dvs});
    o_rem   = o_qbit ? w_sub : w_shift[XLEN-1:0];
    o_dvd   = {i_dvd[XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/m_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit (radix-2 restoring on magnitudes plus
// sign fix-up). Optional M_DIV_RESULT_REUSE_EN keeps the last normal result so an
// identical-operand follow-up op completes in one cycle.
module m_div_unit
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN  = M_XLEN,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      m_con,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem, r_dvd, r_dvs, r_quo, r_result;
  logic             r_neg_q, r_neg_r, r_rem_sel;

  logic             w_accept, w_signed, w_neg1, w_neg2, w_div0, w_ovf, w_qbit;
  logic [XLEN-1:0]  w_abs1, w_abs2, w_spec_res, w_rem_nxt, w_dvd_nxt, w_q_fix, w_r_fix;

`ifdef M_DIV_RESULT_REUSE_EN
  logic [XLEN-1:0]  r_op_a, r_op_b, r_lst_a, r_lst_b, r_lst_q, r_lst_r;
  logic             r_op_sgn, r_lst_sgn, r_lst_vld;
  logic             w_hit;
`endif

  // Accept qualification, operand magnitudes, special cases and sign fix-up.
  always_comb begin
    w_accept   = start && (m_con[3:2] == 2'b10) && (r_state == IDLE) && !kill;
    w_signed   = ~m_con[0];
    w_neg1     = w_signed & rs1_data[XLEN-1];
    w_neg2     = w_signed & rs2_data[XLEN-1];
    w_abs1     = w_neg1 ? -rs1_data : rs1_data;
    w_abs2     = w_neg2 ? -rs2_data : rs2_data;
    w_div0     = (rs2_data == '0);
    w_ovf      = w_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    // Overflow quotient is the dividend itself (-2^(XLEN-1)).
    if (w_div0)     w_spec_res = m_con[1] ? rs1_data : '1;
    else            w_spec_res = m_con[1] ? '0 : rs1_data;
    w_q_fix    = r_neg_q ? -r_quo : r_quo;
    w_r_fix    = r_neg_r ? -r_rem : r_rem;
`ifdef M_DIV_RESULT_REUSE_EN
    w_hit      = r_lst_vld && (r_lst_a == rs1_data) && (r_lst_b == rs2_data) &&
                 (r_lst_sgn == w_signed);
`endif
  end

  div_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_rem  (r_rem),
    .i_dvd  (r_dvd),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_dvd  (w_dvd_nxt),
    .o_qbit (w_qbit)
  );

  // Divider FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
`ifdef M_DIV_RESULT_REUSE_EN
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_sgn  <= 1'b0;
      r_lst_a   <= '0;
      r_lst_b   <= '0;
      r_lst_q   <= '0;
      r_lst_r   <= '0;
      r_lst_sgn <= 1'b0;
      r_lst_vld <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem_sel <= m_con[1];
            r_neg_q   <= w_neg1 ^ w_neg2;
            r_neg_r   <= w_neg1;
            r_dvd     <= w_abs1;
            r_dvs     <= w_abs2;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
`ifdef M_DIV_RESULT_REUSE_EN
            r_op_a    <= rs1_data;
            r_op_b    <= rs2_data;
            r_op_sgn  <= w_signed;
`endif
            if (w_div0 || w_ovf) begin
              r_result <= w_spec_res;
              r_state  <= DONE;
            end
`ifdef M_DIV_RESULT_REUSE_EN
            else if (w_hit) begin
              r_result <= m_con[1] ? r_lst_r : r_lst_q;
              r_state  <= DONE;
            end
`endif
            else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_dvd_nxt;
            r_quo <= {r_quo[XLEN-2:0], w_qbit};
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(XLEN - 1)) r_state <= FIX;
          end
        end
        FIX: begin
          if (kill) begin
            r_state <= IDLE;
          end else begin
            r_result <= r_rem_sel ? w_r_fix : w_q_fix;
            r_state  <= DONE;
`ifdef M_DIV_RESULT_REUSE_EN
            r_lst_a   <= r_op_a;
            r_lst_b   <= r_op_b;
            r_lst_sgn <= r_op_sgn;
            r_lst_q   <= w_q_fix;
            r_lst_r   <= w_r_fix;
            r_lst_vld <= 1'b1;
`endif
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
`ifdef M_DIV_RESULT_REUSE_EN
      // A flush may leave stale operands in flight; never reuse across one.
      if (kill) r_lst_vld <= 1'b0;
`endif
    end
  end

  // Outputs decoded from state; result is the committed register.
  always_comb begin
    busy   = (r_state == CALC) || (r_state == FIX);
    done   = (r_state == DONE);
    result = r_result;
  end

endmodule
